// File: rtl/comp_player.sv
// comp_player: computer opponent for the reaction game.
// A 10-bit XNOR Fibonacci LFSR advances on every tick. When the player is
// idle and the game is enabled, a tick whose pre-advance LFSR value is below
// the difficulty threshold starts a press. The press is held for
// HOLD_CYCLES cycles, followed by a GAP_CYCLES release window.
// Build option: define COMP_PLAYER_GAP_EN to include the GAP state and the
// GAP_CYCLES parameter. Without it, PRESS returns directly to IDLE, and the
// IDLE cycle guarantees at least one low cycle between presses.
//
// state | meaning
// IDLE  | waiting for a tick; difficulty is sampled here only
// PRESS | key held high, counting down HOLD_CYCLES
// GAP   | key released, counting down GAP_CYCLES before the next decision
module comp_player #(
  parameter int LFSR_W      = 10,
  parameter int HOLD_CYCLES = 2
`ifdef COMP_PLAYER_GAP_EN
  ,
  parameter int GAP_CYCLES  = 2
`endif
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              enable,
  input  logic              tick,
  input  logic [8:0]        difficulty,
  output logic              press,
  output logic              press_pulse,
  output logic [LFSR_W-1:0] lfsr_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Down-counter reload values; the counter terminates at zero.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
`ifdef COMP_PLAYER_GAP_EN
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);
`endif

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              press_q;
  logic              press_pulse_q;
  logic [LFSR_W-1:0] lfsr_d;
  logic              fire;

  // XNOR feedback from bits 9 and 6 makes all-ones the lock-up state.
  // Starting from zero, the sequence therefore never reaches it.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ~(lfsr_q[9] ^ lfsr_q[6])};

  // The decision uses the value before this tick's advance.
  assign fire = tick && (lfsr_q < {1'b0, difficulty});

  assign press       = press_q;
  assign press_pulse = press_pulse_q;

  // The LFSR advances on every tick, independent of enable and the FSM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lfsr_q <= '0;
    end else if (tick) begin
      lfsr_q <= lfsr_d;
    end
  end

  // Sequencing FSM with registered press level and first-cycle pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      press_pulse_q <= 1'b0;
    end else if (!enable) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      press_q       <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire) begin
            state_q       <= ST_PRESS;
            cnt_q         <= HOLD_LOAD;
            press_q       <= 1'b1;
            press_pulse_q <= 1'b1;
          end else begin
            cnt_q         <= '0;
            press_q       <= 1'b0;
            press_pulse_q <= 1'b0;
          end
        end
        ST_PRESS: begin
          press_pulse_q <= 1'b0;
          if (cnt_q == 4'd0) begin
`ifdef COMP_PLAYER_GAP_EN
            state_q <= ST_GAP;
            cnt_q   <= GAP_LOAD;
`else
            state_q <= ST_IDLE;
            cnt_q   <= '0;
`endif
            press_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            press_q <= 1'b1;
          end
        end
        ST_GAP: begin
          press_q       <= 1'b0;
          press_pulse_q <= 1'b0;
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          cnt_q         <= '0;
          press_q       <= 1'b0;
          press_pulse_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_player.sv
// tb_comp_player: directed and randomized checks of comp_player against a
// timeline model. Each accepted decision reserves a window of future cycles
// for the press and the release gap.
module tb_comp_player;

  localparam int HOLD = 2;
`ifdef COMP_PLAYER_GAP_EN
  localparam int GAP  = 2;
`else
  localparam int GAP  = 0;
`endif

  logic       Clock;
  logic       Reset;
  logic       enable;
  logic       tick;
  logic [8:0] difficulty;
  logic       press;
  logic       press_pulse;
  logic [9:0] lfsr_q;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_cyc       = 0;
  int m_lfsr      = 0;
  int m_press_end = -1;
  int m_busy_end  = -1;
  bit m_press     = 1'b0;
  bit m_pulse     = 1'b0;

  comp_player dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .enable      (enable),
    .tick        (tick),
    .difficulty  (difficulty),
    .press       (press),
    .press_pulse (press_pulse),
    .lfsr_q      (lfsr_q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int q);
    int fb;
    fb = (((q >> 9) ^ (q >> 6)) & 1) ^ 1;
    return ((q << 1) & 'h3FF) | fb;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit r, input bit e, input bit t, input int d);
    bit new_press;
    if (r) begin
      m_lfsr      = 0;
      m_press_end = -1;
      m_busy_end  = -1;
      new_press   = 1'b0;
    end else begin
      if (e && t && (m_cyc > m_busy_end) && (m_lfsr < d)) begin
        m_press_end = m_cyc + HOLD;
        m_busy_end  = m_cyc + HOLD + GAP;
      end
      if (!e) begin
        m_press_end = m_cyc;
        m_busy_end  = m_cyc;
      end
      if (t) m_lfsr = lfsr_next(m_lfsr);
      new_press = (m_cyc + 1 <= m_press_end);
    end
    m_pulse = new_press && !m_press;
    m_press = new_press;
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit e, input bit t, input logic [8:0] d);
    Reset      = r;
    enable     = e;
    tick       = t;
    difficulty = d;
    @(posedge Clock);
    model_edge(r, e, t, int'(d));
    #1;
    chk("press", 16'(press), 16'(m_press));
    chk("press_pulse", 16'(press_pulse), 16'(m_pulse));
    chk("lfsr_q", 16'(lfsr_q), 16'(m_lfsr));
  endtask

  logic [9:0] seq0[4] = '{10'h001, 10'h003, 10'h007, 10'h00F};
`ifdef COMP_PLAYER_GAP_EN
  logic pat_p[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic pat_u[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic pat_p[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic pat_u[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif

  initial begin
    int first_zero;
    int sel;
    logic [8:0] d;
    Reset      = 1'b1;
    enable     = 1'b0;
    tick       = 1'b0;
    difficulty = '0;

    // Check the reset state with enable and tick active.
    step(1, 1, 1, 9'h1FF);
    chk("reset_press", 16'(press), 16'h0);
    chk("reset_pulse", 16'(press_pulse), 16'h0);
    chk("reset_lfsr", 16'(lfsr_q), 16'h000);

    // Difficulty 0 never presses; check the first LFSR steps.
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 1, 9'h000);
      chk("d0_press", 16'(press), 16'h0);
      if (k <= 4) chk("d0_lfsr_seq", 16'(lfsr_q), 16'(seq0[k-1]));
    end

    // Maximum difficulty with a tick every cycle.
    step(1, 1, 1, 9'h1FF);
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 1, 9'h1FF);
      chk("pattern_press", 16'(press), 16'(pat_p[k-1]));
      chk("pattern_pulse", 16'(press_pulse), 16'(pat_u[k-1]));
    end

    // Reset in the second PRESS cycle aborts the press.
    step(1, 1, 1, 9'h1FF);
    step(0, 1, 1, 9'h1FF);
    chk("pre_abort_press", 16'(press), 16'h1);
    step(0, 1, 1, 9'h1FF);
    step(1, 1, 1, 9'h1FF);
    chk("abort_press", 16'(press), 16'h0);
    chk("abort_pulse", 16'(press_pulse), 16'h0);
    chk("abort_lfsr", 16'(lfsr_q), 16'h000);
    step(0, 1, 0, 9'h1FF);
    chk("abort_no_resume", 16'(press), 16'h0);

    // Dropping enable in the first PRESS cycle returns to IDLE with no gap.
    step(1, 1, 1, 9'h1FF);
    step(0, 1, 1, 9'h1FF);
    step(0, 0, 1, 9'h1FF);
    chk("en_drop_press", 16'(press), 16'h0);
    step(0, 1, 1, 9'h1FF);
    chk("en_repress", 16'(press), 16'h1);
    chk("en_repress_pulse", 16'(press_pulse), 16'h1);

    // Without ticks the LFSR holds and no press occurs.
    step(1, 1, 1, 9'h1FF);
    for (int k = 0; k < 50; k++) begin
      step(0, 1, 0, 9'h1FF);
      chk("notick_lfsr", 16'(lfsr_q), 16'h000);
      chk("notick_press", 16'(press), 16'h0);
    end

    // Check the full LFSR period and that all-ones is never reached.
    step(1, 0, 0, 9'h000);
    first_zero = -1;
    for (int k = 1; k <= 1023; k++) begin
      step(0, 0, 1, 9'h000);
      chk("lfsr_not_3ff", 16'(lfsr_q == 10'h3FF), 16'h0);
      if (lfsr_q == 10'h000 && first_zero < 0) first_zero = k;
    end
    chk("lfsr_period", 16'(first_zero), 16'd1023);

    // Randomized traffic checked cycle by cycle against the model.
    step(1, 1, 0, 9'h000);
    for (int k = 0; k < 3000; k++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      d = 9'h000;
      else if (sel <= 2) d = 9'h1FF;
      else               d = 9'($urandom_range(0, 511));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 1)), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_player.md
COMP_PLAYER -- requirements
Module: comp_player

Interface
REQ-001 Parameter LFSR_W, default 10: width of the pseudo-random generator; fixed at 10 for the specified taps.
REQ-002 Parameter HOLD_CYCLES, default 2: cycles the computer holds its press high, range 1..15.
REQ-003 Parameter GAP_CYCLES, default 2: minimum released cycles after each press, range 1..15.
REQ-004 Clock  input  1  system clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-006 enable  input  1  game-active qualifier; low suppresses all presses.
REQ-007 tick  input  1  one-cycle decision strobe from the game rate divider.
REQ-008 difficulty  input  9  press threshold, normally driven from SW[8:0]; larger means more aggressive.
REQ-009 press  output  1  registered level output, high while the computer "holds" its key, active-high like the user key path.
REQ-010 press_pulse  output  1  registered, high for exactly the first cycle of each press.
REQ-011 lfsr_q  output  10  current LFSR state, for debug and bench checking.

Function
REQ-012 The LFSR shall be Fibonacci and shift left: next = {q[8:0], ~(q[9]^q[6])}, advancing only on cycles with tick=1, regardless of enable or FSM state.
REQ-013 The LFSR shall never reach 10'h3FF from reset; its period shall be 1023 ticks.
REQ-014 FSM states shall be IDLE, PRESS and GAP; press=1 only in PRESS.
REQ-015 IDLE->PRESS shall occur when tick=1, enable=1 and lfsr_q (pre-advance value) < {1'b0, difficulty}; press rises on the next cycle (latency 1).
REQ-016 difficulty=0 shall never press; difficulty=9'h1FF shall press on roughly 50% of ticks.
REQ-017 A 4-bit counter shall hold PRESS for exactly HOLD_CYCLES cycles, then go to GAP for exactly GAP_CYCLES cycles, then to IDLE.
REQ-018 Ticks arriving in PRESS or GAP shall be ignored for the decision but still advance the LFSR.
REQ-019 enable=0 in any state shall force IDLE on the next cycle, with press=0 and the counter cleared.
REQ-020 press_pulse shall equal press AND NOT (press on the previous cycle).
REQ-021 difficulty shall be sampled only in IDLE on the tick cycle; changes at other times have no effect on a press in progress.

Reset
REQ-022 Reset=1 shall force the following on the next edge, overriding enable and tick: state IDLE, lfsr_q=10'h000, counter=0, press=0, press_pulse=0.
REQ-023 Reset asserted mid-PRESS or mid-GAP shall abort the press immediately; no partial hold shall resume afterward.

Configuration
REQ-024 Macro COMP_PLAYER_GAP_EN defined: the GAP state and the GAP_CYCLES parameter shall be present as specified.
REQ-025 Macro COMP_PLAYER_GAP_EN undefined: PRESS shall go directly to IDLE, and press shall be low for at least one cycle between presses.

Verification
REQ-026 Reset, difficulty=0, enable=1, tick each cycle for 20 cycles -> press stays 0; lfsr_q steps 000,001,003,007,00F.
REQ-027 Reset, difficulty=1FF, enable=1, tick each cycle, GAP_EN defined -> press=1 in cycles 2-3 and 0 in cycles 4-5; press_pulse=1 only in cycle 2 of each press.
REQ-028 Reset asserted in the second PRESS cycle -> the next cycle has press=0, press_pulse=0 and lfsr_q=000.
REQ-029 enable dropped in the first PRESS cycle -> press=0 on the next cycle; state returns to IDLE with no GAP.
REQ-030 GAP_EN undefined, difficulty=1FF, tick each cycle -> press pattern 1,1,0 repeats for as long as the comparison holds.
REQ-031 tick held low for 50 cycles with difficulty=1FF -> lfsr_q is unchanged and press=0 throughout.
